// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    // Byte enables presented on every read transaction.
    localparam logic [3:0] RD_SEL = 4'hF;

    // Starvation counter step: counts up to the limit and then holds.
    function automatic logic [3:0] starve_inc(input logic [3:0] cnt, input logic [3:0] lim);
        return (cnt >= lim) ? cnt : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one external memory bus port between instruction fetch and data
// load/store. One transaction is latched at a time and run through a
// req/ack handshake; data normally wins, but a fetch that has been passed
// over STARVE_MAX times in a row is forced through.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instr_rdata,
    output logic              instr_ack,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [3:0]        data_sel,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ack,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              stall,
    output logic              protocol_err
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t        r_state;
    owner_t            r_owner;
    logic [3:0]        r_starve_cnt;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [3:0]        r_bus_sel;
    logic [DATA_W-1:0] r_instr_rdata;
    logic [DATA_W-1:0] r_data_rdata;
    logic              r_instr_ack;
    logic              r_data_ack;
    logic              r_protocol_err;

    logic              w_data_any;
    logic              w_instr_wins;

    // Arbitration decision: data first unless the fetch has starved long enough.
    always_comb begin
        w_data_any   = data_read | data_write;
        w_instr_wins = instr_req & (~w_data_any | (r_starve_cnt == STARVE_LIM));
    end

    // Transaction FSM, latched bus fields, completion pulses and starvation count.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state        <= IDLE;
            r_owner        <= OWN_INSTR;
            r_starve_cnt   <= 4'd0;
            r_bus_req      <= 1'b0;
            r_bus_we       <= 1'b0;
            r_bus_addr     <= {ADDR_W{1'b0}};
            r_bus_wdata    <= {DATA_W{1'b0}};
            r_bus_sel      <= 4'h0;
            r_instr_rdata  <= {DATA_W{1'b0}};
            r_data_rdata   <= {DATA_W{1'b0}};
            r_instr_ack    <= 1'b0;
            r_data_ack     <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_instr_ack    <= 1'b0;
            r_data_ack     <= 1'b0;
            r_protocol_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (instr_req | w_data_any) begin
                        r_state   <= GRANT;
                        r_bus_req <= 1'b1;
                        if (w_instr_wins) begin
                            r_owner     <= OWN_INSTR;
                            r_bus_we    <= 1'b0;
                            r_bus_addr  <= instr_addr;
                            r_bus_wdata <= {DATA_W{1'b0}};
                            r_bus_sel   <= RD_SEL;
                        end else begin
                            // A simultaneous read+write request is resolved as a write.
                            r_owner        <= OWN_DATA;
                            r_bus_we       <= data_write;
                            r_bus_addr     <= data_addr;
                            r_bus_wdata    <= data_write ? data_wdata : {DATA_W{1'b0}};
                            r_bus_sel      <= data_write ? data_sel : RD_SEL;
                            r_protocol_err <= data_read & data_write;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GRANT: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (bus_ack) begin
                        r_state   <= DONE;
                        r_bus_req <= 1'b0;
                        if (r_owner == OWN_INSTR) begin
                            r_instr_rdata <= bus_rdata;
                            r_instr_ack   <= 1'b1;
                        end else begin
                            r_data_ack <= 1'b1;
                            if (!r_bus_we) begin
                                r_data_rdata <= bus_rdata;
                            end else begin
                                r_data_rdata <= r_data_rdata;
                            end
                        end
                    end else begin
                        r_state <= WAIT;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (!instr_req) begin
                r_starve_cnt <= 4'd0;
            end else if (r_state == DONE) begin
                r_starve_cnt <= (r_owner == OWN_DATA) ? starve_inc(r_starve_cnt, STARVE_LIM) : 4'd0;
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end
    end

    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign bus_sel      = r_bus_sel;
    assign instr_rdata  = r_instr_rdata;
    assign data_rdata   = r_data_rdata;
    assign instr_ack    = r_instr_ack;
    assign data_ack     = r_data_ack;
    assign protocol_err = r_protocol_err;

    // Stall is forced low while in reset so the pipeline is released with everything else.
    assign stall = nrst & ((instr_req & ~instr_ack) | (w_data_any & ~data_ack));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers and a bus responder feed
// queues of expected bus transactions and acks, compared as the DUT produces them.
module tb_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } bus_exp_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } dcmd_t;

    logic        clk;
    logic        nrst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic [31:0] instr_rdata;
    logic        instr_ack;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_sel;
    logic [31:0] data_rdata;
    logic        data_ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall;
    logic        protocol_err;

    int          checks;
    int          failures;
    int          cyc;
    int          back_cyc;
    int          perr_cnt;
    int          iack_cnt;
    int          bus_delay;
    bit          bus_en;
    bit          i_busy;
    bit          d_busy;
    bit          i_drop;
    logic [31:0] last_rd;

    bus_exp_t    exp_bus[$];
    logic [31:0] exp_iack[$];
    logic [31:0] exp_dack[$];
    logic [31:0] icmd_q[$];
    dcmd_t       dcmd_q[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .nrst(nrst),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_rdata(instr_rdata), .instr_ack(instr_ack),
        .data_read(data_read), .data_write(data_write), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_sel(data_sel), .data_rdata(data_rdata), .data_ack(data_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .stall(stall), .protocol_err(protocol_err)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0000_0013;
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic push_fetch(input logic [31:0] a);
        icmd_q.push_back(a);
        exp_bus.push_back('{we: 1'b0, addr: a, wdata: 32'h0, sel: 4'hF});
        exp_iack.push_back(mem_rd(a));
    endtask

    task automatic push_data(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] sel);
        dcmd_q.push_back('{rd: rd, wr: wr, addr: a, wdata: wd, sel: sel});
        exp_bus.push_back('{we: wr, addr: a, wdata: (wr ? wd : 32'h0), sel: (wr ? sel : 4'hF)});
        if (!wr) last_rd = mem_rd(a);
        exp_dack.push_back(last_rd);
    endtask

    task automatic cycle_counter();
        forever begin
            @(posedge clk);
            if (bus_ack) back_cyc = cyc;
            cyc++;
        end
    endtask

    task automatic bus_model();
        forever begin
            @(negedge clk);
            #1;
            if (bus_en && bus_req && !bus_ack) begin
                repeat (1 + bus_delay) @(negedge clk);
                #1;
                bus_ack   = 1'b1;
                bus_rdata = mem_rd(bus_addr);
                @(negedge clk);
                #1;
                bus_ack   = 1'b0;
            end
        end
    endtask

    task automatic instr_driver();
        forever begin
            @(negedge clk);
            #1;
            if (i_busy && instr_ack) begin
                instr_req = 1'b0;
                i_busy    = 1'b0;
            end
            if (i_drop && i_busy && bus_req) begin
                instr_req = 1'b0;
                i_busy    = 1'b0;
                i_drop    = 1'b0;
            end
            if (!i_busy && icmd_q.size() > 0) begin
                instr_addr = icmd_q.pop_front();
                instr_req  = 1'b1;
                i_busy     = 1'b1;
            end
        end
    endtask

    task automatic data_driver();
        dcmd_t c;
        forever begin
            @(negedge clk);
            #1;
            if (d_busy && data_ack) begin
                data_read  = 1'b0;
                data_write = 1'b0;
                d_busy     = 1'b0;
            end
            if (!d_busy && dcmd_q.size() > 0) begin
                c          = dcmd_q.pop_front();
                data_read  = c.rd;
                data_write = c.wr;
                data_addr  = c.addr;
                data_wdata = c.wdata;
                data_sel   = c.sel;
                d_busy     = 1'b1;
            end
        end
    endtask

    task automatic monitor();
        logic        prev_req;
        bus_exp_t    e;
        bus_exp_t    cur;
        bus_exp_t    held;
        logic [31:0] x;
        prev_req = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            cur = '{we: bus_we, addr: bus_addr, wdata: bus_wdata, sel: bus_sel};
            if (bus_req && !prev_req) begin
                checks++;
                if (exp_bus.size() == 0) begin
                    failures++;
                    $display("FAIL bus_unexpected got we=%b addr=%h wdata=%h sel=%b required no request",
                             cur.we, cur.addr, cur.wdata, cur.sel);
                end else begin
                    e = exp_bus.pop_front();
                    if (cur !== e) begin
                        failures++;
                        $display("FAIL bus_txn got we=%b addr=%h wdata=%h sel=%b required we=%b addr=%h wdata=%h sel=%b",
                                 cur.we, cur.addr, cur.wdata, cur.sel, e.we, e.addr, e.wdata, e.sel);
                    end
                end
                held = cur;
            end else if (bus_req && prev_req) begin
                checks++;
                if (cur !== held) begin
                    failures++;
                    $display("FAIL bus_stable got addr=%h we=%b required addr=%h we=%b",
                             cur.addr, cur.we, held.addr, held.we);
                end
            end
            prev_req = bus_req;

            if (instr_ack) begin
                iack_cnt++;
                checks++;
                if (exp_iack.size() == 0) begin
                    failures++;
                    $display("FAIL iack_unexpected got rdata=%h required no ack", instr_rdata);
                end else begin
                    x = exp_iack.pop_front();
                    if (instr_rdata !== x) begin
                        failures++;
                        $display("FAIL iack_rdata got %h required %h", instr_rdata, x);
                    end
                end
                checks++;
                if (back_cyc !== cyc - 1) begin
                    failures++;
                    $display("FAIL iack_latency got bus_ack cycle %0d required %0d", back_cyc, cyc - 1);
                end
            end

            if (data_ack) begin
                checks++;
                if (exp_dack.size() == 0) begin
                    failures++;
                    $display("FAIL dack_unexpected got rdata=%h required no ack", data_rdata);
                end else begin
                    x = exp_dack.pop_front();
                    if (data_rdata !== x) begin
                        failures++;
                        $display("FAIL dack_rdata got %h required %h", data_rdata, x);
                    end
                end
                checks++;
                if (back_cyc !== cyc - 1) begin
                    failures++;
                    $display("FAIL dack_latency got bus_ack cycle %0d required %0d", back_cyc, cyc - 1);
                end
            end

            if (protocol_err) begin
                perr_cnt++;
                checks++;
                if (bus_req !== 1'b1) begin
                    failures++;
                    $display("FAIL perr_timing got bus_req=%b required 1", bus_req);
                end
            end
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_bus.size() == 0 && exp_iack.size() == 0 && exp_dack.size() == 0 &&
                icmd_q.size() == 0 && dcmd_q.size() == 0 && !i_busy && !d_busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_req, bus_we, instr_ack, data_ack, stall, protocol_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b required 000000",
                     {bus_req, bus_we, instr_ack, data_ack, stall, protocol_err});
        end
        checks++;
        if ({bus_addr, bus_wdata, bus_sel, instr_rdata, data_rdata} !== 132'b0) begin
            failures++;
            $display("FAIL reset_data got addr=%h wdata=%h sel=%b irdata=%h drdata=%h required all 0",
                     bus_addr, bus_wdata, bus_sel, instr_rdata, data_rdata);
        end
        #2 nrst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        bus_en = 1'b0;
        push_fetch(32'h0000_0040);
        for (int i = 0; i < 20 && !bus_req; i++) @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_grant got bus_req=%b required 1", bus_req);
        end
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({bus_req, instr_ack, data_ack, stall} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid_outputs got req/iack/dack/stall=%b required 0000",
                     {bus_req, instr_ack, data_ack, stall});
        end
        @(negedge clk);
        exp_bus.push_back('{we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0, sel: 4'hF});
        bus_en = 1'b1;
        #2 nrst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_idle_regrant got bus_req=%b required 1", bus_req);
        end
        wait_drain(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rst_mid_drain got queues pending required empty");
        end
    endtask

    task automatic test_lone_fetch();
        bit ok;
        bus_delay = 1;
        push_fetch(32'h0000_0100);
        for (int i = 0; i < 20 && !bus_req; i++) @(negedge clk);
        checks++;
        if ({bus_req, stall} !== 2'b11) begin
            failures++;
            $display("FAIL fetch_stall_wait got req/stall=%b required 11", {bus_req, stall});
        end
        for (int i = 0; i < 20 && !instr_ack; i++) @(negedge clk);
        checks++;
        if ({instr_ack, stall, instr_rdata} !== {1'b1, 1'b0, 32'h0000_0013}) begin
            failures++;
            $display("FAIL fetch_done got ack=%b stall=%b rdata=%h required ack=1 stall=0 rdata=00000013",
                     instr_ack, stall, instr_rdata);
        end
        wait_drain(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fetch_drain got queues pending required empty");
        end
    endtask

    task automatic test_data_priority();
        bit ok;
        bus_delay = 0;
        push_data(1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011);
        push_fetch(32'h0000_0300);
        wait_drain(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL priority_drain got queues pending required empty");
        end
    endtask

    task automatic test_starvation();
        bit ok;
        int p0;
        p0 = perr_cnt;
        bus_delay = 0;
        for (int i = 0; i < 4; i++) push_data(1'b1, 1'b0, 32'h0000_1000 + 32'(4 * i), 32'h0, 4'h0);
        push_fetch(32'h0000_0400);
        push_data(1'b1, 1'b0, 32'h0000_1010, 32'h0, 4'h0);
        wait_drain(400, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL starve_drain got queues pending required empty");
        end
        checks++;
        if (perr_cnt - p0 !== 0) begin
            failures++;
            $display("FAIL starve_perr got %0d pulses required 0", perr_cnt - p0);
        end
    endtask

    task automatic test_read_write_conflict();
        bit ok;
        int p0;
        p0 = perr_cnt;
        push_data(1'b1, 1'b1, 32'h0000_3000, 32'h1234_5678, 4'b1100);
        wait_drain(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rw_drain got queues pending required empty");
        end
        checks++;
        if (perr_cnt - p0 !== 1) begin
            failures++;
            $display("FAIL rw_perr got %0d pulses required 1", perr_cnt - p0);
        end
        checks++;
        if (data_rdata !== last_rd) begin
            failures++;
            $display("FAIL rw_rdata_hold got %h required %h", data_rdata, last_rd);
        end
    endtask

    task automatic test_drop_mid_wait();
        bit ok;
        int a0;
        a0 = iack_cnt;
        bus_delay = 2;
        i_drop = 1'b1;
        push_fetch(32'h0000_0500);
        for (int i = 0; i < 30 && i_drop; i++) @(negedge clk);
        checks++;
        if ({i_drop, bus_req, stall} !== 3'b010) begin
            failures++;
            $display("FAIL drop_wait got drop_pending/req/stall=%b required 010", {i_drop, bus_req, stall});
        end
        wait_drain(300, ok);
        repeat (8) @(negedge clk);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drop_drain got queues pending required empty");
        end
        checks++;
        if (iack_cnt - a0 !== 1) begin
            failures++;
            $display("FAIL drop_ack_count got %0d required 1", iack_cnt - a0);
        end
    endtask

    // Test sequence; background drivers, responder and monitor are forked from here.
    initial begin
        nrst = 1'b0;
        instr_req = 1'b0; instr_addr = 32'h0;
        data_read = 1'b0; data_write = 1'b0; data_addr = 32'h0; data_wdata = 32'h0; data_sel = 4'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        checks = 0; failures = 0; cyc = 0; back_cyc = -10; perr_cnt = 0; iack_cnt = 0;
        bus_delay = 0; bus_en = 1'b1; i_busy = 1'b0; d_busy = 1'b0; i_drop = 1'b0;
        last_rd = 32'h0;
        fork
            cycle_counter();
            bus_model();
            instr_driver();
            data_driver();
            monitor();
        join_none
        test_reset();
        test_reset_mid_wait();
        test_lone_fetch();
        test_data_priority();
        test_starvation();
        test_read_write_conflict();
        test_drop_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
